// File: rtl/dmem_bridge.sv
// CPU data-memory bridge: forwards aligned loads/stores to a valid/ready bus,
// serves a small MMIO block locally, and reports faults and bus timeouts.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_data_out,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_data_in,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_we,
    output logic [3:0]  bus_req_be,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);
    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   tmo_q, tmo_d;
    logic            fault_q, fault_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   cycle_q, cycle_d;
    logic [DW-1:0]   scratch_q, scratch_d;

    logic            req_c;
    logic            fault_now_c;
    logic            nop_store_c;
    logic            is_mmio_c;
    logic            local_c;
    logic            expire_c;
    logic [DW-1:0]   mmio_rdata_c;

    // Classify the CPU request presented in IDLE
    always_comb begin
        req_c       = dmem_read | dmem_write;
        fault_now_c = (dmem_read & dmem_write)
                    | ((dmem_byte_enable == 4'b1111) && (dmem_addr[1:0] != 2'b00))
                    | (((dmem_byte_enable == 4'b0011) || (dmem_byte_enable == 4'b1100))
                       && dmem_addr[0]);
        nop_store_c = dmem_write & (dmem_byte_enable == 4'b0000);
        is_mmio_c   = (dmem_addr[31:16] == MMIO_BASE[31:16]);
        local_c     = fault_now_c | nop_store_c | is_mmio_c;
        expire_c    = (tmo_q + 32'd1) >= TMO_LIMIT;
    end

    // MMIO read mux: word 0 is the cycle counter, word 1 the scratch register
    always_comb begin
        mmio_rdata_c = '0;
        if (dmem_addr[15:2] == 14'd0) begin
            mmio_rdata_c = cycle_q;
        end else if (dmem_addr[15:2] == 14'd1) begin
            mmio_rdata_c = scratch_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a real handshake/response wins over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    state_d = local_c ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    state_d = S_RESP;
                end else if (expire_c) begin
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                if (bus_rsp_valid || expire_c) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register (stall also sees the request)
    always_comb begin
        mem_stall     = 1'b0;
        bus_req_valid = 1'b0;
        case (state_q)
            S_IDLE:  mem_stall = req_c;
            S_REQ: begin
                mem_stall     = 1'b1;
                bus_req_valid = 1'b1;
            end
            S_RESP:  mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // Datapath next values: payload capture, timeout, load data, MMIO registers
    always_comb begin
        tmo_d     = tmo_q;
        fault_d   = 1'b0;
        data_d    = data_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    if (fault_now_c) begin
                        fault_d = 1'b1;
                        data_d  = '0;
                    end else if (nop_store_c) begin
                        data_d = data_q;
                    end else if (is_mmio_c) begin
                        if (dmem_read) begin
                            data_d = mmio_rdata_c;
                        end else if (dmem_addr[15:2] == 14'd1) begin
                            for (int i = 0; i < 4; i++) begin
                                if (dmem_byte_enable[i]) begin
                                    scratch_d[8*i +: 8] = dmem_data_out[8*i +: 8];
                                end
                            end
                        end
                    end else begin
                        tmo_d   = '0;
                        addr_d  = {dmem_addr[31:2], 2'b00};
                        we_d    = dmem_write;
                        be_d    = dmem_byte_enable;
                        wdata_d = dmem_data_out;
                    end
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 32'd1;
                if (!bus_req_ready && expire_c) begin
                    fault_d = 1'b1;
                    data_d  = '0;
                end
            end
            S_RESP: begin
                tmo_d = tmo_q + 32'd1;
                if (bus_rsp_valid) begin
                    if (bus_rsp_err) begin
                        fault_d = 1'b1;
                        data_d  = '0;
                    end else if (!we_q) begin
                        data_d = bus_rsp_rdata;
                    end
                end else if (expire_c) begin
                    fault_d = 1'b1;
                    data_d  = '0;
                end
            end
            default: fault_d = 1'b0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q     <= '0;
            fault_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cycle_q   <= '0;
            scratch_q <= '0;
        end else begin
            tmo_q     <= tmo_d;
            fault_q   <= fault_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
        end
    end

    assign dmem_data_in  = data_q;
    assign mem_fault     = fault_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_we    = we_q;
    assign bus_req_be    = be_q;
    assign bus_req_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized self-checking bench for dmem_bridge against a transaction-level model.
module tb_dmem_bridge;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_data_in;
    logic        mem_stall;
    logic        mem_fault;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYCLES(TMO), .MMIO_BASE(32'hFFFF_0000)) dut (
        .clk(clk), .reset(reset),
        .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_data_in(dmem_data_in),
        .mem_stall(mem_stall), .mem_fault(mem_fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
        .bus_req_be(bus_req_be), .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err(bus_rsp_err)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_data;
    logic [31:0] m_scratch;
    logic [31:0] m_cnt;

    // Expectations for the current cycle, set by the driver
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_valid, exp_fault;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;

    logic [3:0] be_tab [10] = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Free-running cycle counter as seen by software
    always @(posedge clk) m_cnt <= reset ? 32'd0 : m_cnt + 32'd1;

    // Per-cycle compare of DUT outputs against model expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("bus_req_valid", 32'(bus_req_valid), 32'(exp_valid));
            chk("mem_fault", 32'(mem_fault), 32'(exp_fault));
            chk("dmem_data_in", dmem_data_in, exp_data);
            if (exp_valid) begin
                chk("bus_req_addr", bus_req_addr, exp_addr);
                chk("bus_req_we", 32'(bus_req_we), 32'(exp_we));
                chk("bus_req_be", 32'(bus_req_be), 32'(exp_be));
                chk("bus_req_wdata", bus_req_wdata, exp_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with stray bus responses that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_read     = 1'b0;
            dmem_write    = 1'b0;
            dmem_addr     = $urandom;
            bus_req_ready = 1'(($urandom % 2));
            bus_rsp_valid = 1'(($urandom % 2));
            bus_rsp_rdata = $urandom;
            bus_rsp_err   = 1'(($urandom % 2));
            exp_stall = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0; exp_data = m_data;
            tick();
        end
    endtask

    // One CPU access; the bus side answers after the given delays.
    // Returns observed stall, request-valid and fault cycle counts.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int rdy_dly, input int rsp_dly,
                          input logic err, input logic [31:0] rdata,
                          output int nst, output int nval, output int nflt);
        logic        fault_now, nop, mmio, tfault;
        logic [31:0] newdata;
        int          t, r, reqc;
        fault_now = (rd && wr) || (be == 4'hF && addr[1:0] != 2'b00)
                  || ((be == 4'h3 || be == 4'hC) && addr[0]);
        nop     = wr && (be == 4'h0);
        mmio    = (addr[31:16] == 16'hFFFF);
        newdata = m_data;
        tfault  = 1'b0;
        t = 0; reqc = 0; r = rdy_dly + 1;
        if (fault_now) begin
            tfault  = 1'b1;
            newdata = 32'd0;
        end else if (nop) begin
            newdata = m_data;
        end else if (mmio) begin
            if (rd) begin
                if (addr[15:2] == 14'd0)      newdata = m_cnt;
                else if (addr[15:2] == 14'd1) newdata = m_scratch;
                else                          newdata = 32'd0;
            end else if (addr[15:2] == 14'd1) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
            end
        end else if (rdy_dly >= int'(TMO)) begin
            tfault = 1'b1; newdata = 32'd0; t = TMO; reqc = TMO;
        end else begin
            reqc = r;
            if (rsp_dly == 0 || r + rsp_dly <= int'(TMO) - 1) begin
                t = r + rsp_dly + 1;
                if (err) begin
                    tfault = 1'b1; newdata = 32'd0;
                end else if (rd) begin
                    newdata = rdata;
                end
            end else begin
                tfault = 1'b1; newdata = 32'd0;
                t = (r + 1 > int'(TMO)) ? r + 1 : int'(TMO);
            end
        end
        nst = 0; nval = 0; nflt = 0;
        for (int k = 0; k <= t + 1; k++) begin
            dmem_read        = (k <= t) ? rd : 1'b0;
            dmem_write       = (k <= t) ? wr : 1'b0;
            dmem_addr        = addr;
            dmem_byte_enable = be;
            dmem_data_out    = wd;
            bus_req_ready    = (k == 1 + rdy_dly);
            if (k == 1 + r + rsp_dly) begin
                bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata; bus_rsp_err = err;
            end else if (k >= 1 && k <= reqc && ($urandom % 4) == 0) begin
                bus_rsp_valid = 1'b1; bus_rsp_rdata = $urandom; bus_rsp_err = 1'(($urandom % 2));
            end else begin
                bus_rsp_valid = 1'b0; bus_rsp_rdata = $urandom; bus_rsp_err = 1'b0;
            end
            exp_stall = (k <= t);
            exp_valid = (k >= 1 && k <= reqc);
            exp_fault = (k == t + 1) && tfault;
            exp_data  = (k == t + 1) ? newdata : m_data;
            exp_addr  = {addr[31:2], 2'b00};
            exp_we    = wr;
            exp_be    = be;
            exp_wdata = wd;
            #1;
            if (mem_stall) nst++;
            if (bus_req_valid) nval++;
            if (mem_fault) nflt++;
            tick();
        end
        m_data = newdata;
    endtask

    initial begin
        int          nst, nval, nflt, rdl, rsl, sel;
        logic        rd, wr;
        logic [31:0] a, v1, v2;
        logic [3:0]  b;

        reset = 1'b1;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_addr = '0; dmem_data_out = '0;
        dmem_byte_enable = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_data = '0; m_scratch = '0;
        chk("rst_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_we", 32'(bus_req_we), 32'd0);
        chk("rst_be", 32'(bus_req_be), 32'd0);
        chk("rst_addr", bus_req_addr, 32'd0);
        chk("rst_wdata", bus_req_wdata, 32'd0);
        chk("rst_data", dmem_data_in, 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk_en = 1'b1;

        // Directed: minimum-latency load
        access(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, nst, nval, nflt);
        chk("load_stalls", 32'(nst), 32'd3);
        chk("load_data", dmem_data_in, 32'hDEADBEEF);
        chk("load_fault", 32'(nflt), 32'd0);
        idle(1);
        // Directed: store with delayed ready
        access(1'b0, 1'b1, 32'h0000_2002, 4'hC, 32'hABCD_0000, 4, 0, 1'b0, 32'h1234_5678, nst, nval, nflt);
        chk("store_valid_cycles", 32'(nval), 32'd5);
        chk("store_addr", bus_req_addr, 32'h0000_2000);
        chk("store_stalls", 32'(nst), 32'd7);
        chk("store_keeps_data", dmem_data_in, 32'hDEADBEEF);
        // Directed: timeout with no response, late response ignored
        access(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 0, 20, 1'b0, 32'h5555_AAAA, nst, nval, nflt);
        chk("tmo_stalls", 32'(nst), 32'd9);
        chk("tmo_fault", 32'(nflt), 32'd1);
        chk("tmo_data", dmem_data_in, 32'd0);
        idle(3);
        // Directed: misaligned and read+write faults
        access(1'b1, 1'b0, 32'h0000_1001, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        chk("misalign_stalls", 32'(nst), 32'd1);
        chk("misalign_valid", 32'(nval), 32'd0);
        chk("misalign_fault", 32'(nflt), 32'd1);
        access(1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        chk("rdwr_fault", 32'(nflt), 32'd1);
        chk("rdwr_valid", 32'(nval), 32'd0);
        // Directed: MMIO scratch and cycle counter
        access(1'b0, 1'b1, 32'hFFFF_0004, 4'h5, 32'h1122_3344, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        access(1'b1, 1'b0, 32'hFFFF_0004, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        chk("scratch_read", dmem_data_in, 32'h0022_0044);
        chk("mmio_stalls", 32'(nst), 32'd1);
        access(1'b1, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        v1 = dmem_data_in;
        idle(5);
        access(1'b1, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        v2 = dmem_data_in;
        chk("cnt_delta", v2 - v1, 32'd7);
        access(1'b1, 1'b0, 32'hFFFF_0010, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        chk("mmio_other", dmem_data_in, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom % 10);
            rd  = (sel == 0) || (sel >= 5);
            wr  = (sel <= 4);
            b   = be_tab[$urandom % 10];
            if (($urandom % 4) == 0) begin
                a = 32'hFFFF_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
                if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
            end
            if (($urandom % 5) == 0) begin
                rdl = int'($urandom_range(0, 10));
                rsl = int'($urandom_range(0, 12));
            end else begin
                rdl = int'($urandom_range(0, 3));
                rsl = int'($urandom_range(0, 3));
            end
            access(rd, wr, a, b, $urandom, rdl, rsl, ($urandom % 6) == 0, $urandom, nst, nval, nflt);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset during RESP abandons the access
        chk_en = 1'b0;
        dmem_read = 1'b1; dmem_write = 1'b0; dmem_addr = 32'h0000_3000;
        dmem_byte_enable = 4'hF; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        chk("pre_reset_stall", 32'(mem_stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dmem_read = 1'b0;
        #1;
        chk("post_reset_valid", 32'(bus_req_valid), 32'd0);
        chk("post_reset_stall", 32'(mem_stall), 32'd0);
        chk("post_reset_data", dmem_data_in, 32'd0);
        m_data = '0; m_scratch = '0;
        chk_en = 1'b1;
        access(1'b1, 1'b0, 32'hFFFF_0004, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        access(1'b1, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0, nst, nval, nflt);
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles in REQ+RESP before forced fault completion.
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000: upper 16 bits select the internal register region.
REQ-003 Single clock `clk`; reset `reset` is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 dmem_addr  in  32  CPU data address.
REQ-007 dmem_data_out  in  32  CPU store data, lane-aligned.
REQ-008 dmem_read / dmem_write  in  1 each  CPU load / store request, held stable while mem_stall=1.
REQ-009 dmem_byte_enable  in  4  CPU byte lanes.
REQ-010 dmem_data_in  out  32  load data returned to CPU.
REQ-011 mem_stall  out  1  CPU must hold pipeline and request while high.
REQ-012 mem_fault  out  1  one-cycle pulse with completion of a faulted access.
REQ-013 bus_req_valid / bus_req_ready  out / in  1  request handshake.
REQ-014 bus_req_addr  out  32  word-aligned address ({dmem_addr[31:2],2'b00}).
REQ-015 bus_req_we / bus_req_be / bus_req_wdata  out  1 / 4 / 32  write flag, lanes, data.
REQ-016 bus_rsp_valid / bus_rsp_rdata / bus_rsp_err  in  1 / 32 / 1  response.

Function
REQ-017 FSM states IDLE, REQ, RESP, DONE; new request = dmem_read|dmem_write sampled in IDLE.
REQ-018 mem_stall SHALL be 1 in IDLE when a new request is present, 1 in REQ and RESP, 0 in DONE and in IDLE with no request.
REQ-019 External access: IDLE->REQ; REQ holds bus_req_valid=1 and stable payload until bus_req_ready=1, then ->RESP; RESP waits bus_rsp_valid=1, latches bus_rsp_rdata (loads) into dmem_data_in, ->DONE; DONE->IDLE unconditionally.
REQ-020 Minimum external latency: request at cycle N, valid&ready at N+1, rsp_valid at N+2, DONE at N+3; three stall cycles.
REQ-021 bus_rsp_err=1 in RESP SHALL complete normally with mem_fault=1 in DONE and dmem_data_in=0.
REQ-022 Timeout counter clears on IDLE->REQ, increments each REQ/RESP cycle; on reaching TIMEOUT_CYCLES ->DONE with mem_fault=1, dmem_data_in=0, bus_req_valid dropped.
REQ-023 bus_rsp_valid outside RESP SHALL be ignored (late responses after timeout discarded).
REQ-024 Fault without bus access (IDLE->DONE, mem_fault=1, data 0): dmem_read and dmem_write both high; byte_enable=4'b1111 with addr[1:0]!=0; byte_enable=4'b0011/4'b1100 with addr[0]!=0.
REQ-025 Store with byte_enable=0 SHALL complete IDLE->DONE, no bus access, no fault.
REQ-026 MMIO (addr[31:16]==MMIO_BASE[31:16]) SHALL be served internally IDLE->DONE, one stall cycle, no bus activity.
REQ-027 MMIO offset 0x0: free-running 32-bit cycle counter, read-only, wraps 0xFFFF_FFFF->0; writes ignored.
REQ-028 MMIO offset 0x4: 32-bit scratch register, byte-enable-masked writes, readable.
REQ-029 Other MMIO offsets read 0, writes ignored, no fault.
REQ-030 dmem_data_in SHALL hold its last value between loads; stores do not modify it.

Reset
REQ-031 On reset: FSM=IDLE, bus_req_valid=0, bus_req_we=0, bus_req_be=0, bus_req_addr=0, bus_req_wdata=0, dmem_data_in=0, mem_fault=0, timeout counter=0, cycle counter=0, scratch=0.
REQ-032 Reset asserted mid-access (REQ/RESP) SHALL abandon it; bus_req_valid=0 in the cycle after reset is sampled.

Verification
REQ-033 Load 0x0000_1000, ready=1 immediately, rsp next cycle rdata=0xDEADBEEF -> stall 3 cycles, DONE dmem_data_in=0xDEADBEEF, mem_fault=0.
REQ-034 Store addr 0x0000_2002, be=4'b1100, data 0xABCD0000, ready delayed 4 cycles -> bus_req_addr=0x0000_2000, payload stable 5 cycles, stall ends after rsp.
REQ-035 Load with ready=1 but no rsp, TIMEOUT_CYCLES=8 -> DONE after 8 REQ/RESP cycles, mem_fault pulse, data 0; later rsp_valid ignored.
REQ-036 Word load at 0x0000_1001 -> no bus_req_valid, one stall cycle, mem_fault=1; read+write simultaneous -> same.
REQ-037 Store 0x11223344 be=4'b0101 to 0xFFFF_0004, then load 0xFFFF_0004 -> 0x00220044; two loads of 0xFFFF_0000 k cycles apart differ by k.
REQ-038 Assert reset during RESP -> next cycle IDLE, bus_req_valid=0, mem_stall=0 with no request.
